npu_output_drain: RTL and testbench

//  Downstream of npu_top. Snapshots the cluster's output_vectors on the cluster-done pulse.

---
 rtl/npu_pkg.sv | 18 +
 rtl/npu_output_drain_if.sv | 17 +
 rtl/npu_next_pe_finder.sv | 26 ++
 rtl/npu_output_drain.sv | 109 ++++++++++
 tb/tb_npu_output_drain.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/npu_pkg.sv
// Shared NPU cluster geometry, drain FSM state type and PE index helper.
// Geometry here must match the npu_top instance that feeds the drain.
package npu_pkg;
    localparam int OUTPUT_WIDTH     = 32;
    localparam int SUBARRAY_ROWS    = 4;
    localparam int PE_ARRAY_ROWS    = 2;
    localparam int PE_ARRAY_COLS    = 2;
    localparam int NUM_LARGE_ARRAYS = 2;
    localparam int NUM_PES          = NUM_LARGE_ARRAYS * PE_ARRAY_ROWS * PE_ARRAY_COLS;
    localparam int IDX_W            = (NUM_PES > 1) ? $clog2(NUM_PES) : 1;
    localparam int VEC_W            = SUBARRAY_ROWS * OUTPUT_WIDTH;

    typedef enum logic [1:0] {DRN_IDLE, DRN_STREAM, DRN_DONE} drain_state_e;

    function automatic int pe_flat_idx(input int arr, input int row, input int col);
        return (arr * PE_ARRAY_ROWS + row) * PE_ARRAY_COLS + col;
    endfunction
endpackage

// File: rtl/npu_output_drain_if.sv
// AXI-Stream result channel: one PE result vector per beat, tuser = flat PE index.
// Master drives data/valid/last, slave drives ready.
interface npu_output_drain_if
    import npu_pkg::*;
#(
    parameter int DATA_W = VEC_W,
    parameter int USER_W = IDX_W
);
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, tuser, tlast, tvalid, input tready);
    modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/npu_next_pe_finder.sv
// Finds the lowest set mask bit strictly above i_idx (or from bit 0 when i_from_start).
// Purely combinational, zero latency; no flow control.
module npu_next_pe_finder
    import npu_pkg::*;
#(
    parameter int N = NUM_PES,
    parameter int W = IDX_W
) (
    input  logic [N-1:0] i_mask,
    input  logic         i_from_start,
    input  logic [W-1:0] i_idx,
    output logic [W-1:0] o_idx,
    output logic         o_found
);
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        // Scan downwards so the last hit written is the lowest qualifying bit.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_mask[i] && (i_from_start || (i > int'(i_idx)))) begin
                o_idx   = W'(i);
                o_found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/npu_output_drain.sv
// Snapshots cluster results on done_pulse and streams one AXIS beat per enabled PE.
// Latency: first tvalid one cycle after done_pulse; subsequent beats back-to-back.
// Backpressure: beat held stable while tready is low; clear aborts the stream.
module npu_output_drain
    import npu_pkg::*;
#(
    parameter int OUTPUT_WIDTH     = npu_pkg::OUTPUT_WIDTH,
    parameter int SUBARRAY_ROWS    = npu_pkg::SUBARRAY_ROWS,
    parameter int PE_ARRAY_ROWS    = npu_pkg::PE_ARRAY_ROWS,
    parameter int PE_ARRAY_COLS    = npu_pkg::PE_ARRAY_COLS,
    parameter int NUM_LARGE_ARRAYS = npu_pkg::NUM_LARGE_ARRAYS,
    localparam int NPE = NUM_LARGE_ARRAYS * PE_ARRAY_ROWS * PE_ARRAY_COLS,
    localparam int IW  = (NPE > 1) ? $clog2(NPE) : 1,
    localparam int VW  = SUBARRAY_ROWS * OUTPUT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              done_pulse,
    input  logic              clear,
    input  logic [NPE-1:0]    pe_mask,
    input  logic [NPE*VW-1:0] output_vectors,
    npu_output_drain_if.master m_axis,
    output logic              drain_busy,
    output logic              drain_done,
    output logic              overrun,
    output logic [15:0]       beat_count
);
    drain_state_e      r_state, w_state_nxt;
    logic [NPE*VW-1:0] r_shadow;
    logic [NPE-1:0]    r_mask;
    logic [IW-1:0]     r_idx;
    logic [15:0]       r_beat_count;
    logic              r_overrun;

    logic [IW-1:0]     w_first_idx, w_next_idx;
    logic              w_first_found, w_next_found;
    logic              w_tvalid, w_hs, w_capture;

    npu_next_pe_finder #(.N(NPE), .W(IW)) u_first_finder (
        .i_mask       (pe_mask),
        .i_from_start (1'b1),
        .i_idx        ('0),
        .o_idx        (w_first_idx),
        .o_found      (w_first_found)
    );

    npu_next_pe_finder #(.N(NPE), .W(IW)) u_next_finder (
        .i_mask       (r_mask),
        .i_from_start (1'b0),
        .i_idx        (r_idx),
        .o_idx        (w_next_idx),
        .o_found      (w_next_found)
    );

    assign w_tvalid  = (r_state == DRN_STREAM);
    assign w_hs      = w_tvalid && m_axis.tready;
    assign w_capture = (r_state == DRN_IDLE) && done_pulse && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= DRN_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            DRN_IDLE:   if (done_pulse) w_state_nxt = w_first_found ? DRN_STREAM : DRN_DONE;
            DRN_STREAM: if (w_hs && !w_next_found) w_state_nxt = DRN_DONE;
            DRN_DONE:   w_state_nxt = DRN_IDLE;
            default:    w_state_nxt = DRN_IDLE;
        endcase
        if (clear) w_state_nxt = DRN_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow     <= '0;
            r_mask       <= '0;
            r_idx        <= '0;
            r_beat_count <= '0;
            r_overrun    <= 1'b0;
        end else begin
            if (clear)                                r_overrun <= 1'b0;
            else if (done_pulse && r_state != DRN_IDLE) r_overrun <= 1'b1;

            if (w_capture) begin
                r_shadow     <= output_vectors;
                r_mask       <= pe_mask;
                r_idx        <= w_first_idx;
                r_beat_count <= '0;
            end else if (w_hs && !clear) begin
                r_beat_count  <= r_beat_count + 16'd1;
                r_mask[r_idx] <= 1'b0;
                if (w_next_found) r_idx <= w_next_idx;
            end
        end
    end

    // Beat fields derive from stable state, so they cannot change during a stall.
    assign m_axis.tvalid = w_tvalid;
    assign m_axis.tdata  = w_tvalid ? r_shadow[r_idx*VW +: VW] : '0;
    assign m_axis.tuser  = w_tvalid ? r_idx : '0;
    assign m_axis.tlast  = w_tvalid && !w_next_found;

    assign drain_busy = (r_state != DRN_IDLE);
    assign drain_done = (r_state == DRN_DONE);
    assign overrun    = r_overrun;
    assign beat_count = r_beat_count;
endmodule

// File: tb/tb_npu_output_drain.sv
// Scoreboard bench for npu_output_drain: expected beats queued at capture, popped on handshake.
module tb_npu_output_drain;
    import npu_pkg::*;

    typedef struct packed {
        logic [IDX_W-1:0] user;
        logic [VEC_W-1:0] data;
        logic             last;
    } beat_t;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     done_pulse = 1'b0;
    logic                     clear = 1'b0;
    logic [NUM_PES-1:0]       pe_mask = '0;
    logic [NUM_PES*VEC_W-1:0] output_vectors = '0;
    logic                     drain_busy, drain_done, overrun;
    logic [15:0]              beat_count;

    npu_output_drain_if #(.DATA_W(VEC_W), .USER_W(IDX_W)) axis ();

    npu_output_drain dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .done_pulse     (done_pulse),
        .clear          (clear),
        .pe_mask        (pe_mask),
        .output_vectors (output_vectors),
        .m_axis         (axis),
        .drain_busy     (drain_busy),
        .drain_done     (drain_done),
        .overrun        (overrun),
        .beat_count     (beat_count)
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    int    checks = 0, errors = 0;
    int    cyc = 0, done_cnt = 0, done_cyc = 0, beats_seen = 0, tv_cnt = 0;
    int    first_hs_cyc = 0, last_hs_cyc = 0, tr_mode = 2;
    bit    prev_stall = 1'b0;
    beat_t prev_beat, mon_exp;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NUM_PES*VEC_W-1:0] make_vec(input int seed);
        logic [NUM_PES*VEC_W-1:0] v;
        v = '0;
        for (int a = 0; a < NUM_LARGE_ARRAYS; a++)
            for (int r = 0; r < PE_ARRAY_ROWS; r++)
                for (int c = 0; c < PE_ARRAY_COLS; c++)
                    v[pe_flat_idx(a, r, c)*VEC_W +: VEC_W] =
                        {SUBARRAY_ROWS{OUTPUT_WIDTH'(seed + pe_flat_idx(a, r, c))}};
        return v;
    endfunction

    always @(posedge clk) cyc++;

    initial forever begin
        @(posedge clk);
        #1;
        if (tr_mode == 0)      axis.tready = 1'b1;
        else if (tr_mode == 1) axis.tready = ((cyc % 4) == 0);
    end

    always @(negedge clk) begin
        if (drain_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (axis.tvalid) tv_cnt++;
        if (axis.tvalid && prev_stall) begin
            chk("hold_tdata", axis.tdata, prev_beat.data);
            chk("hold_tuser", axis.tuser, prev_beat.user);
            chk("hold_tlast", axis.tlast, prev_beat.last);
        end
        if (axis.tvalid && axis.tready) begin
            beats_seen++;
            if (beats_seen == 1) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("extra_beat", exp_q.size(), 1);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("tuser", axis.tuser, mon_exp.user);
                chk("tdata", axis.tdata, mon_exp.data);
                chk("tlast", axis.tlast, mon_exp.last);
            end
        end
        prev_stall     = axis.tvalid && !axis.tready;
        prev_beat.data = axis.tdata;
        prev_beat.user = axis.tuser;
        prev_beat.last = axis.tlast;
    end

    task automatic start_drain(input logic [NUM_PES-1:0] m, input int seed, input bit push);
        logic [NUM_PES*VEC_W-1:0] vec;
        beat_t b;
        vec = make_vec(seed);
        @(posedge clk);
        #1;
        pe_mask        = m;
        output_vectors = vec;
        done_pulse     = 1'b1;
        if (push) begin
            beats_seen = 0;
            for (int p = 0; p < NUM_PES; p++) begin
                if (m[p]) begin
                    b.user = IDX_W'(p);
                    b.data = vec[p*VEC_W +: VEC_W];
                    b.last = ((m >> (p + 1)) == 0);
                    exp_q.push_back(b);
                end
            end
        end
        @(posedge clk);
        #1;
        done_pulse = 1'b0;
        if (push) chk("first_tvalid", axis.tvalid, (m != 0));
    endtask

    task automatic wait_done(input int bound);
        int start;
        start = done_cnt;
        for (int i = 0; i < bound && done_cnt == start; i++) @(posedge clk);
        #1;
        chk("drain_done_seen", (done_cnt != start), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tvs, dc;
        axis.tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", axis.tvalid, 0);
        chk("rst_tdata", axis.tdata, 0);
        chk("rst_tuser", axis.tuser, 0);
        chk("rst_tlast", axis.tlast, 0);
        chk("rst_busy", drain_busy, 0);
        chk("rst_done", drain_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_count", beat_count, 0);
        rst_n   = 1'b1;
        tr_mode = 0;

        // All PEs enabled, sink always ready.
        start_drain(8'hFF, 0, 1);
        wait_done(100);
        chk("full_beats", beats_seen, 8);
        chk("full_count", beat_count, 8);
        chk("full_b2b", last_hs_cyc - first_hs_cyc, 7);
        chk("full_done_lat", done_cyc, last_hs_cyc + 1);
        chk("full_q_empty", exp_q.size(), 0);

        // Sparse mask.
        start_drain(8'b1010_0100, 16, 1);
        wait_done(100);
        chk("sparse_beats", beats_seen, 3);
        chk("sparse_count", beat_count, 3);
        chk("sparse_q_empty", exp_q.size(), 0);

        // Empty mask: no beats, still completes.
        tvs = tv_cnt;
        start_drain(8'h00, 32, 1);
        wait_done(20);
        chk("empty_no_tvalid", tv_cnt - tvs, 0);
        chk("empty_count", beat_count, 0);
        chk("empty_idle", drain_busy, 0);

        // Stalling sink with live inputs changing after capture.
        tr_mode = 1;
        start_drain(8'hFF, 64, 1);
        output_vectors = make_vec(200);
        pe_mask        = '0;
        wait_done(300);
        chk("stall_beats", beats_seen, 8);
        chk("stall_count", beat_count, 8);
        chk("stall_q_empty", exp_q.size(), 0);
        tr_mode = 0;

        // Second done_pulse mid-stream.
        start_drain(8'hFF, 96, 1);
        for (int i = 0; i < 50 && beats_seen < 3; i++) @(posedge clk);
        start_drain(8'h0F, 300, 0);
        wait_done(100);
        chk("ovr_flag", overrun, 1);
        chk("ovr_beats", beats_seen, 8);
        chk("ovr_count", beat_count, 8);
        chk("ovr_q_empty", exp_q.size(), 0);

        // Abort with clear after five beats.
        start_drain(8'hFF, 128, 1);
        for (int i = 0; i < 50 && beat_count != 16'd5; i++) begin
            @(posedge clk);
            #1;
        end
        chk("clr_overrun_before", overrun, 1);
        tr_mode     = 2;
        axis.tready = 1'b0;
        clear       = 1'b1;
        dc          = done_cnt;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clr_tvalid", axis.tvalid, 0);
        chk("clr_busy", drain_busy, 0);
        chk("clr_overrun", overrun, 0);
        chk("clr_count", beat_count, 5);
        repeat (4) @(posedge clk);
        #1;
        chk("clr_no_done", done_cnt - dc, 0);
        exp_q.delete();
        tr_mode = 0;

        // Asynchronous reset mid-stream, then a normal drain.
        start_drain(8'hFF, 160, 1);
        for (int i = 0; i < 50 && beats_seen < 4; i++) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", axis.tvalid, 0);
        chk("arst_tdata", axis.tdata, 0);
        chk("arst_busy", drain_busy, 0);
        chk("arst_count", beat_count, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_drain(8'b1010_0100, 180, 1);
        wait_done(100);
        chk("post_rst_beats", beats_seen, 3);
        chk("post_rst_count", beat_count, 3);
        chk("post_rst_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
